// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART transmitter among N byte requesters.
// It latches the granted byte, pulses tx_start, and holds the grant until tx_done_tick or a watchdog abort.
module uart_tx_arbiter #(
  parameter int N       = 4,
  parameter int DBIT    = 8,
  parameter int TIMEOUT = 4096
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N-1:0]      req,
  input  logic [N*DBIT-1:0] data,
  input  logic              tx_done_tick,
  output logic              tx_start,
  output logic [DBIT-1:0]   tx_din,
  output logic [N-1:0]      gnt,
  output logic [N-1:0]      ack,
  output logic              err_tick
);

  localparam int PW = $clog2(N);
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {IDLE, START, BUSY} state_t;

  state_t          state_reg, state_next;
  logic [PW-1:0]   ptr_reg;
  logic [PW-1:0]   idx_reg;
  logic [CW-1:0]   cnt_reg;
  logic [N-1:0]    gnt_reg;
  logic [N-1:0]    ack_reg;
  logic [DBIT-1:0] din_reg;
  logic            err_reg;

  logic            found;
  logic [PW-1:0]   pick;
  logic [PW-1:0]   cand;
  logic            timeout;
  logic [PW-1:0]   ptr_next;

  // First requester at or after ptr, searching upward with wrap-around.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    cand  = '0;
    for (int k = 0; k < N; k++) begin
      cand = PW'((int'(ptr_reg) + k) % N);
      if (!found && req[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  generate
    if (TIMEOUT > 0) begin : g_wdog
      assign timeout = (cnt_reg == CW'(TIMEOUT - 1));
    end else begin : g_no_wdog
      assign timeout = 1'b0;
    end
  endgenerate

  assign ptr_next = (idx_reg == PW'(N - 1)) ? '0 : idx_reg + 1'b1;

  // State register plus the datapath registers it steers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      ptr_reg   <= '0;
      idx_reg   <= '0;
      cnt_reg   <= '0;
      gnt_reg   <= '0;
      ack_reg   <= '0;
      din_reg   <= '0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      ack_reg   <= '0;
      err_reg   <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (found) begin
            gnt_reg <= {{(N-1){1'b0}}, 1'b1} << pick;
            idx_reg <= pick;
            din_reg <= data[int'(pick)*DBIT +: DBIT];
          end
        end
        START: cnt_reg <= '0;
        BUSY: begin
          // Done wins over a coincident timeout.
          if (tx_done_tick || timeout) begin
            gnt_reg <= '0;
            ptr_reg <= ptr_next;
            if (tx_done_tick) ack_reg <= gnt_reg;
            else              err_reg <= 1'b1;
          end else if (cnt_reg != CW'(TIMEOUT)) begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (found) state_next = START;
      START:   state_next = BUSY;
      BUSY:    if (tx_done_tick || timeout) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    tx_start = (state_reg == START);
    tx_din   = din_reg;
    gnt      = gnt_reg;
    ack      = ack_reg;
    err_tick = err_reg;
  end

endmodule
